// File: rtl/picoview_pkg.sv
// Shared widths, defaults and sweep FSM state encoding.
package picoview_pkg;

  localparam int unsigned DEF_FIFO_DEPTH    = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned COUNT_W  = 16;
  localparam int unsigned LEVEL_W  = 9;
  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_TRIGGER = 3'd2,
    ST_WAIT    = 3'd3,
    ST_STORE   = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_valid_c,
  output logic             o_full_c,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_valid_c = (r_level != '0);
  assign o_full_c  = (r_level == LW'(DEPTH));
  assign o_level   = r_level;
  assign o_head_c  = o_valid_c ? r_mem[r_rd_ptr] : '0;

  // Pop only real data; a push at full is accepted when a pop frees the slot.
  assign w_pop  = i_pop && o_valid_c;
  assign w_push = i_push && (!o_full_c || w_pop);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Delay-sweep sequencer: steps the ETS sampler delay, triggers it, and queues results.
module sweep_sequencer
  import picoview_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  delay_start,
  input  logic [DATA_W-1:0]  delay_step,
  input  logic [COUNT_W-1:0] point_count,
  output logic               sampler_request_run,
  output logic [DATA_W-1:0]  sampler_delay,
  input  logic               sampler_result_ready,
  input  logic [DATA_W-1:0]  sampler_result,
  output logic [DATA_W-1:0]  result_data,
  output logic               result_valid,
  input  logic               result_pop,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [LEVEL_W-1:0] fifo_level
);

  localparam int unsigned FIFO_LW = $clog2(FIFO_DEPTH) + 1;

  sweep_state_t        r_state,      w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [DATA_W-1:0]   r_delay,      w_delay_nxt;
  logic [DATA_W-1:0]   r_step,       w_step_nxt;
  logic [COUNT_W-1:0]  r_points,     w_points_nxt;
  logic [DATA_W-1:0]   r_capture,    w_capture_nxt;
  logic                r_done,       w_done_nxt;
  logic                r_aborted,    w_aborted_nxt;
  logic                r_run,        w_run_nxt;
  logic                r_busy,       w_busy_nxt;
  logic                w_push;
  logic                w_fifo_full;
  logic [FIFO_LW-1:0]  w_fifo_level;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_delay      <= '0;
      r_step       <= '0;
      r_points     <= '0;
      r_capture    <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_delay      <= w_delay_nxt;
      r_step       <= w_step_nxt;
      r_points     <= w_points_nxt;
      r_capture    <= w_capture_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_run        <= w_run_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state and datapath updates; abort outranks all in-flight work.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_delay_nxt      = r_delay;
    w_step_nxt       = r_step;
    w_points_nxt     = r_points;
    w_capture_nxt    = r_capture;
    w_done_nxt       = r_done;
    w_aborted_nxt    = r_aborted;
    w_push           = 1'b0;

    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_aborted_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_delay_nxt      = delay_start;
            w_step_nxt       = delay_step;
            w_points_nxt     = point_count;
            w_settle_cnt_nxt = '0;
            w_aborted_nxt    = 1'b0;
            if (point_count == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_done_nxt  = 1'b0;
              w_state_nxt = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            w_state_nxt = ST_TRIGGER;
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + SETTLE_W'(1);
          end
        end
        ST_TRIGGER: begin
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (sampler_result_ready) begin
            w_capture_nxt = sampler_result;
            w_state_nxt   = ST_STORE;
          end
        end
        ST_STORE: begin
          if (!w_fifo_full || result_pop) begin
            w_push       = 1'b1;
            w_points_nxt = r_points - COUNT_W'(1);
            if (r_points == COUNT_W'(1)) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_delay_nxt      = r_delay + r_step;
              w_settle_cnt_nxt = '0;
              w_state_nxt      = ST_SETTLE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_run_nxt  = (w_state_nxt == ST_TRIGGER);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Result queue between sampler and host.
  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_data    (r_capture),
    .i_pop     (result_pop),
    .o_head_c  (result_data),
    .o_valid_c (result_valid),
    .o_full_c  (w_fifo_full),
    .o_level   (w_fifo_level)
  );

  assign sampler_request_run = r_run;
  assign sampler_delay       = r_delay;
  assign busy                = r_busy;
  assign done                = r_done;
  assign aborted             = r_aborted;
  assign fifo_level          = LEVEL_W'(w_fifo_level);

endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16 (power of two, 2..256); result FIFO entries.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4 (1..255); cycles the delay setting is held before each trigger.
REQ-003 SHALL have ports clk in 1 (sole clock, rising edge) and reset_n in 1; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have ports start in 1 (one-cycle sweep request) and abort in 1 (one-cycle cancel).
REQ-005 SHALL have ports delay_start in 32 (first delay setting), delay_step in 32 (per-point increment) and point_count in 16 (points per sweep).
REQ-006 SHALL have ports sampler_request_run out 1 (run pulse to the ETS sampler) and sampler_delay out 32 (delay_characteristics to the sampler).
REQ-007 SHALL have ports sampler_result_ready in 1 (sampler result strobe) and sampler_result in 32 (sampler result word).
REQ-008 SHALL have ports result_data out 32, result_valid out 1 (FIFO non-empty) and result_pop in 1 (consume head).
REQ-009 SHALL have ports busy out 1, done out 1 (sticky), aborted out 1 (sticky) and fifo_level out 9 (current entry count).

Function
REQ-010 SHALL implement states IDLE, SETTLE, TRIGGER, WAIT, STORE.
REQ-011 IDLE + start: latch config; sampler_delay<=delay_start; points_left<=point_count; clear done and aborted; go to SETTLE, or stay IDLE with done=1 if point_count==0.
REQ-012 SETTLE: count SETTLE_CYCLES cycles with sampler_delay stable, then go to TRIGGER.
REQ-013 TRIGGER: assert sampler_request_run for exactly one cycle, then go to WAIT.
REQ-014 WAIT: hold until sampler_result_ready==1; capture sampler_result that cycle; go to STORE.
REQ-015 STORE: push the captured word when the FIFO is not full or result_pop is asserted that cycle; otherwise stall in STORE with no data loss.
REQ-016 After a push: decrement points_left; if it reaches 0, go to IDLE with done=1; else sampler_delay<=sampler_delay+delay_step (mod 2^32) and go to SETTLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start while busy SHALL be ignored.
REQ-019 abort in any non-IDLE state: IDLE next cycle, aborted=1, done unchanged, FIFO contents retained, no further sampler_request_run.
REQ-020 abort and start in the same cycle in IDLE: start wins. Abort in IDLE SHALL have no effect.
REQ-021 sampler_result_ready outside WAIT SHALL be ignored.
REQ-022 FIFO SHALL be first-word-fall-through: result_data = head whenever result_valid=1.
REQ-023 result_pop while empty SHALL be ignored.
REQ-024 Simultaneous push and pop SHALL leave fifo_level unchanged, including at full.
REQ-025 Config inputs SHALL be sampled only at sweep start; changes mid-sweep have no effect.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE; sampler_request_run=0, sampler_delay=0, busy=0, done=0, aborted=0, FIFO empty (result_valid=0, fifo_level=0), result_data=0.
REQ-027 Reset mid-sweep SHALL discard all progress; first post-reset sampler_request_run requires a new start.

Structure
REQ-028 State encoding and default FIFO_DEPTH/SETTLE_CYCLES SHALL live in shared package picoview_pkg.
REQ-029 FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, FWFT, level output); the FSM stays in sweep_sequencer.

Verification
REQ-030 delay_start=100, step=10, count=3, sampler model replies 5 cycles after run: exactly 3 pulses, delays 100/110/120, each held 4 cycles before its pulse; FIFO holds 3 results in order; done=1.
REQ-031 count=0, start: no sampler_request_run; done=1 on the next cycle; busy never asserted.
REQ-032 FIFO_DEPTH=4, count=6, no pops: FSM stalls in STORE with level=4; popping resumes the sweep and all 6 results arrive in order.
REQ-033 abort during WAIT of point 2: IDLE next cycle, aborted=1, done=0, level=1, no further pulses.
REQ-034 delay_start=0xFFFFFFF8, step=8, count=2: delays 0xFFFFFFF8 then 0x00000000.
REQ-035 reset_n low during SETTLE: all outputs at reset values immediately; stray sampler_result_ready afterwards causes no push.
